// File: rtl/spi_slave.sv
// SPI responder: oversamples sck/cs/mosi on clk and exchanges one MSB-first word per frame.
// Optional `SPI_SLAVE_FRAME_ERR_EN adds a frame_err pulse on frames aborted before W samples.
module spi_slave #(
  parameter int SPI_MAX_WIDTH_LOG = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sck,
  input  logic                              cs,
  input  logic                              mosi,
  output logic                              miso,
  input  logic                              config_req,
  input  logic [SPI_MAX_WIDTH_LOG+1:0]      config_data,
  input  logic [2**SPI_MAX_WIDTH_LOG-1:0]   tx_din,
  output logic [2**SPI_MAX_WIDTH_LOG-1:0]   rx_dout,
  output logic                              rx_valid,
  output logic                              busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                              frame_err
`endif
);

  localparam int DW = 2**SPI_MAX_WIDTH_LOG;
  localparam int CW = SPI_MAX_WIDTH_LOG;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sck_sync_q, sck_sync_d;
  logic [1:0]      cs_sync_q, cs_sync_d;
  logic [1:0]      mosi_sync_q, mosi_sync_d;
  logic            sck_prev_q, sck_prev_d;
  logic            cs_prev_q, cs_prev_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic [CW-1:0]   width_q, width_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   tx_sr_q, tx_sr_d;
  logic [DW-1:0]   rx_sr_q, rx_sr_d;
  logic [DW-1:0]   rx_dout_q, rx_dout_d;
  logic            rx_valid_q, rx_valid_d;
  logic            miso_q, miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic            frame_err_q, frame_err_d;
`endif

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic last_sample;

  assign sck_s  = sck_sync_q[1];
  assign cs_s   = cs_sync_q[1];
  assign mosi_s = mosi_sync_q[1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  assign lead_edge   = cpol_q ? sck_fall : sck_rise;
  assign trail_edge  = cpol_q ? sck_rise : sck_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign last_sample = sample_edge && (cnt_q == width_q);

  always_comb begin
    sck_sync_d  = {sck_sync_q[0], sck};
    cs_sync_d   = {cs_sync_q[0], cs};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE: begin
        if (cs_rise)          state_d = IDLE;
        else if (last_sample) state_d = DONE;
      end
      DONE:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // miso is presented then the tx register shifts; cpha=0 pre-presents the MSB at cs fall,
  // so the register is loaded already shifted by one.
  always_comb begin
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    width_d    = width_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_dout_d  = rx_dout_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (config_req) begin
          cpol_d  = config_data[CW+1];
          cpha_d  = config_data[CW];
          width_d = config_data[CW-1:0];
        end
        if (cs_fall) begin
          cnt_d   = '0;
          rx_sr_d = '0;
          if (cpha_q) begin
            tx_sr_d = tx_din;
          end else begin
            tx_sr_d = tx_din << 1;
            miso_d  = tx_din[width_q];
          end
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          miso_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_d = 1'b1;
`endif
        end else begin
          if (shift_edge) begin
            miso_d  = tx_sr_q[width_q];
            tx_sr_d = tx_sr_q << 1;
          end
          if (sample_edge) begin
            rx_sr_d = {rx_sr_q[DW-2:0], mosi_s};
            cnt_d   = cnt_q + CW'(1);
          end
          if (last_sample) begin
            rx_dout_d  = rx_sr_d;
            rx_valid_d = 1'b1;
            miso_d     = 1'b0;
          end
        end
      end
      DONE:    miso_d = 1'b0;
      default: miso_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      width_q     <= '1;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_dout_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      width_q     <= width_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_dout_q   <= rx_dout_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign miso     = miso_q;
  assign rx_dout  = rx_dout_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: the bench plays SPI master and compares against a word-level model.
module tb_spi_slave;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        config_req = 1'b0;
  logic [5:0]  config_data = '0;
  logic [15:0] tx_din = '0;
  logic        miso;
  logic [15:0] rx_dout;
  logic        rx_valid;
  logic        busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic        frame_err;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = -1;
  int ferr_cnt = 0;

  logic        cfg_cpol = 1'b0;
  logic        cfg_cpha = 1'b0;
  int          cfg_w = 16;
  logic [15:0] exp_rx = '0;

  spi_slave #(.SPI_MAX_WIDTH_LOG(4)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .config_req(config_req), .config_data(config_data), .tx_din(tx_din),
    .rx_dout(rx_dout), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      last_valid_cyc = cyc;
    end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (frame_err) ferr_cnt = ferr_cnt + 1;
`endif
  end

  function automatic logic [15:0] mask_w(input logic [15:0] v, input int w);
    logic [15:0] m;
    m = (w >= 16) ? 16'hFFFF : ((16'(1) << w) - 16'(1));
    return v & m;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic p, input logic h, input int w);
    @(negedge clk);
    config_req  = 1'b1;
    config_data = {p, h, 4'(w - 1)};
    @(negedge clk);
    config_req = 1'b0;
    sck = p;
    cfg_cpol = p;
    cfg_cpha = h;
    cfg_w = w;
    wait_clk(6);
  endtask

  // Master side of one frame; cfg_at >= 0 pulses a width-4 config request before that bit.
  task automatic do_frame(input logic [15:0] tx, input logic [15:0] mo, input int nbits,
                          input int cfg_at, input int extra, output logic [15:0] got,
                          output int ec, output logic miso_end, output logic busy_mid);
    int w;
    logic p, h;
    w = cfg_w; p = cfg_cpol; h = cfg_cpha;
    got = '0; ec = 0;
    tx_din = tx;
    @(negedge clk);
    if (!h) mosi = mo[w-1];
    cs = 1'b0;
    wait_clk(H);
    busy_mid = busy;
    tx_din = 16'($urandom);
    for (int i = 0; i < nbits; i++) begin
      if (i == cfg_at) begin
        config_req = 1'b1;
        config_data = {1'b0, 1'b0, 4'd3};
        @(negedge clk);
        config_req = 1'b0;
      end
      if (!h) begin
        got = {got[14:0], miso};
        ec = cyc;
        sck = ~p;
        wait_clk(H);
        sck = p;
        if (i + 1 < w) mosi = mo[w-2-i];
        wait_clk(H);
      end else begin
        sck = ~p;
        mosi = mo[w-1-i];
        wait_clk(H);
        got = {got[14:0], miso};
        ec = cyc;
        sck = p;
        wait_clk(H);
      end
    end
    for (int e = 0; e < extra; e++) begin
      sck = ~sck;
      wait_clk(H);
    end
    miso_end = miso;
    cs = 1'b1;
    wait_clk(H);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(1);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    total++; if (rx_dout !== 16'h0) begin bad++; $display("FAIL reset_rx_dout got=%h exp=0000", rx_dout); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
`endif
    wait_clk(4);
  endtask

  task automatic run_checked(input string nm, input logic [15:0] tx, input logic [15:0] mo);
    logic [15:0] got; int ec; logic me, bm; int v0;
    v0 = valid_cnt;
    do_frame(tx, mo, cfg_w, -1, 0, got, ec, me, bm);
    exp_rx = mask_w(mo, cfg_w);
    total++; if (rx_dout !== exp_rx) begin bad++; $display("FAIL %s_rx got=%h exp=%h", nm, rx_dout, exp_rx); end
    total++; if (got !== mask_w(tx, cfg_w)) begin bad++; $display("FAIL %s_master_rx got=%h exp=%h", nm, got, mask_w(tx, cfg_w)); end
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL %s_pulses got=%0d exp=1", nm, valid_cnt - v0); end
    total++; if (last_valid_cyc !== ec + 3) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", nm, last_valid_cyc, ec + 3); end
    total++; if (bm !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s_busy mid=%b end=%b exp=1/0", nm, bm, busy); end
  endtask

  task automatic test_mode0;
    set_cfg(1'b0, 1'b0, 8);
    run_checked("mode0", 16'h00A5, 16'h003C);
  endtask

  task automatic test_mode3;
    set_cfg(1'b1, 1'b1, 16);
    run_checked("mode3", 16'h1234, 16'hBEEF);
  endtask

  task automatic test_mode1_extra;
    logic [15:0] got; int ec; logic me, bm; int v0;
    set_cfg(1'b0, 1'b1, 4);
    v0 = valid_cnt;
    do_frame(16'h000C, 16'h0009, 4, -1, 6, got, ec, me, bm);
    exp_rx = 16'h0009;
    total++; if (rx_dout !== exp_rx) begin bad++; $display("FAIL mode1_rx got=%h exp=%h", rx_dout, exp_rx); end
    total++; if (got !== 16'h000C) begin bad++; $display("FAIL mode1_master_rx got=%h exp=000c", got); end
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL mode1_extra_pulses got=%0d exp=1", valid_cnt - v0); end
    total++; if (me !== 1'b0) begin bad++; $display("FAIL mode1_done_miso got=%b exp=0", me); end
  endtask

  task automatic test_abort;
    logic [15:0] got; int ec; logic me, bm; int v0, f0;
    set_cfg(1'b0, 1'b0, 8);
    v0 = valid_cnt; f0 = ferr_cnt;
    do_frame(16'h5A5A, 16'h00FF, 5, -1, 0, got, ec, me, bm);
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL abort_pulses got=%0d exp=0", valid_cnt - v0); end
    total++; if (rx_dout !== exp_rx) begin bad++; $display("FAIL abort_rx_hold got=%h exp=%h", rx_dout, exp_rx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL abort_frame_err got=%0d exp=1", ferr_cnt - f0); end
`else
    f0 = f0 + 0;
`endif
  endtask

  task automatic test_config_midframe;
    logic [15:0] got; int ec; logic me, bm; int v0;
    set_cfg(1'b0, 1'b0, 8);
    v0 = valid_cnt;
    do_frame(16'hC3E7, 16'h9D6B, 8, 3, 0, got, ec, me, bm);
    exp_rx = mask_w(16'h9D6B, 8);
    total++; if (rx_dout !== exp_rx) begin bad++; $display("FAIL cfgmid_rx got=%h exp=%h", rx_dout, exp_rx); end
    total++; if (got !== 16'h00E7) begin bad++; $display("FAIL cfgmid_master_rx got=%h exp=00e7", got); end
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL cfgmid_pulses got=%0d exp=1", valid_cnt - v0); end
    set_cfg(1'b0, 1'b0, 4);
    run_checked("cfg4", 16'hFFF6, 16'hABC5);
  endtask

  task automatic test_reset_midframe;
    logic [15:0] got; int ec; logic me, bm; int v0;
    set_cfg(1'b0, 1'b0, 8);
    tx_din = 16'h00FF;
    @(negedge clk);
    mosi = 1'b1;
    cs = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b1; wait_clk(H);
      sck = 1'b0; wait_clk(H);
    end
    rst_n = 1'b0;
    wait_clk(1);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
    total++; if (rx_dout !== 16'h0) begin bad++; $display("FAIL rstmid_rx_dout got=%h exp=0000", rx_dout); end
    total++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_busy_valid got=%b%b exp=00", busy, rx_valid); end
    rst_n = 1'b1;
    exp_rx = '0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_w = 16;
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) begin
      sck = 1'b1; wait_clk(H);
      sck = 1'b0; wait_clk(H);
    end
    total++; if (busy !== 1'b0 || valid_cnt !== v0) begin bad++; $display("FAIL cs_low_at_release busy=%b pulses=%0d exp=0/0", busy, valid_cnt - v0); end
    cs = 1'b1;
    wait_clk(H);
    run_checked("after_rst", 16'h8001, 16'h7E3D);
    got = '0; ec = 0; me = 1'b0; bm = 1'b0;
  endtask

  task automatic test_random;
    logic p, h; int w;
    for (int n = 0; n < 6; n++) begin
      p = 1'($urandom_range(1, 0));
      h = 1'($urandom_range(1, 0));
      w = (n == 0) ? 1 : int'($urandom_range(16, 1));
      set_cfg(p, h, w);
      run_checked("random", 16'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3;
    test_mode1_extra;
    test_abort;
    test_config_midframe;
    test_reset_midframe;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
